// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit: state encoding,
// instruction class / ALU opcode constants, NZCV bit positions and the
// wait-counter width.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    ADDR,
    MEM_RD,
    MEM_WR,
    WB,
    WB_LD
  } state_e;

  // Instruction class, IR[27:26]; 2'b1x is undefined
  localparam logic [1:0] DP = 2'b00;
  localparam logic [1:0] LS = 2'b01;

  // ALU opcodes, IR[24:21]
  localparam logic [3:0] ADD = 4'h4;
  localparam logic [3:0] TST = 4'h8;
  localparam logic [3:0] TEQ = 4'h9;
  localparam logic [3:0] CMP = 4'hA;
  localparam logic [3:0] CMN = 4'hB;

  // NZCV bit indices
  localparam int unsigned N = 3;
  localparam int unsigned Z = 2;
  localparam int unsigned C = 1;
  localparam int unsigned V = 0;

  localparam int unsigned WAIT_W = 8;

  // Compare ops write flags only and never write back a result
  function automatic logic is_cmp(input logic [3:0] op);
    return (op == TST) || (op == TEQ) || (op == CMP) || (op == CMN);
  endfunction

endpackage

// File: rtl/mcu_mem_timer.sv
// Data-memory wait timer.
//   clk, rst_n  : clock, async active-low reset
//   active      : FSM is in MEM_RD or MEM_WR
//   mem_ready   : memory completion
//   timeout_c   : combinational, high in the wait cycle that exhausts MEM_TO
module mcu_mem_timer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TO = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic mem_ready,
  output logic timeout_c
);

  logic [WAIT_W-1:0] wait_cnt;

  // Held at zero outside the memory states, so it is clear on entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!active) begin
      wait_cnt <= '0;
    end else if (!mem_ready) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Fires on the cycle whose increment would bring the count to MEM_TO,
  // so the request is held exactly MEM_TO cycles; a ready in that same
  // cycle wins.
  assign timeout_c = active && !mem_ready && (wait_cnt == WAIT_W'(MEM_TO - 1));

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM downstream of instruction fetch.
//   clk, rst_n        : clock, async active-low reset
//   IR, W_IR_valid    : latched instruction and its condition-pass flag
//   alu_flags         : ALU NZCV result, valid in EXEC
//   mem_ready         : data memory completion
//   write_ir/write_pc : fetch strobes (FETCH)
//   NZCV              : architectural flags back to fetch
//   alu_op/alu_src_imm: ALU control (EXEC/ADDR)
//   latch_ab/latch_alu_out/rf_we/rf_wsel/mem_rd/mem_wr : datapath strobes
//   illegal, bus_err  : registered one-cycle error pulses
//   retired_cnt       : completed-instruction counter
module multicycle_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned MEM_TO = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      IR,
  input  logic             W_IR_valid,
  input  logic [3:0]       alu_flags,
  input  logic             mem_ready,
  output logic             write_ir,
  output logic             write_pc,
  output logic [3:0]       NZCV,
  output logic [3:0]       alu_op,
  output logic             alu_src_imm,
  output logic             latch_ab,
  output logic             latch_alu_out,
  output logic             rf_we,
  output logic             rf_wsel,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired_cnt
);

  state_e state, state_nxt;

  logic [1:0] ir_class;
  logic [3:0] ir_op;
  logic       ir_s_l;
  logic       ir_imm;
  logic       op_cmp;
  logic       in_mem;
  logic       timeout_c;
  logic       retire_c;
  logic       unused_ir;

  assign ir_class  = IR[27:26];
  assign ir_imm    = IR[25];
  assign ir_op     = IR[24:21];
  assign ir_s_l    = IR[20];   // S for DP, L for LS
  assign op_cmp    = is_cmp(ir_op);
  assign in_mem    = (state == MEM_RD) || (state == MEM_WR);
  assign unused_ir = ^{IR[31:28], IR[19:0]};

  mcu_mem_timer #(.MEM_TO(MEM_TO)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .active    (in_mem),
    .mem_ready (mem_ready),
    .timeout_c (timeout_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:  state_nxt = W_IR_valid ? DECODE : FETCH;
      DECODE: begin
        if (ir_class == DP)      state_nxt = EXEC;
        else if (ir_class == LS) state_nxt = ADDR;
        else                     state_nxt = FETCH;
      end
      EXEC:   state_nxt = op_cmp ? FETCH : WB;
      ADDR:   state_nxt = ir_s_l ? MEM_RD : MEM_WR;
      MEM_RD: begin
        if (mem_ready)      state_nxt = WB_LD;
        else if (timeout_c) state_nxt = FETCH;
      end
      MEM_WR: if (mem_ready || timeout_c) state_nxt = FETCH;
      WB:     state_nxt = FETCH;
      WB_LD:  state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  // Moore outputs; gated by rst_n so every strobe drops the moment reset asserts
  always_comb begin
    write_ir      = 1'b0;
    write_pc      = 1'b0;
    latch_ab      = 1'b0;
    latch_alu_out = 1'b0;
    rf_we         = 1'b0;
    rf_wsel       = 1'b0;
    mem_rd        = 1'b0;
    mem_wr        = 1'b0;
    alu_op        = 4'h0;
    alu_src_imm   = 1'b0;
    if (rst_n) begin
      case (state)
        FETCH:  begin write_ir = 1'b1; write_pc = 1'b1; end
        DECODE: latch_ab = 1'b1;
        EXEC:   begin latch_alu_out = 1'b1; alu_op = ir_op; alu_src_imm = ir_imm; end
        ADDR:   begin latch_alu_out = 1'b1; alu_op = ADD; alu_src_imm = 1'b1; end
        MEM_RD: mem_rd = 1'b1;
        MEM_WR: mem_wr = 1'b1;
        WB:     rf_we = 1'b1;
        WB_LD:  begin rf_we = 1'b1; rf_wsel = 1'b1; end
        default: ;
      endcase
    end
  end

  assign retire_c = (state == WB) || (state == WB_LD) ||
                    ((state == EXEC) && op_cmp) ||
                    ((state == MEM_WR) && mem_ready);

  // Flags, retire counter and error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      NZCV        <= 4'h0;
      retired_cnt <= '0;
      illegal     <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      if ((state == EXEC) && (ir_s_l || op_cmp)) NZCV <= alu_flags;
      if (retire_c) retired_cnt <= retired_cnt + CNT_W'(1);
      illegal <= (state == DECODE) && ir_class[1];
      bus_err <= timeout_c;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit. Strobes are compared as
// {write_ir, write_pc, latch_ab, latch_alu_out, rf_we, rf_wsel, mem_rd, mem_wr}.
module tb_multicycle_control_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] IR;
  logic        W_IR_valid;
  logic [3:0]  alu_flags;
  logic        mem_ready;
  logic        write_ir, write_pc, alu_src_imm, latch_ab, latch_alu_out;
  logic        rf_we, rf_wsel, mem_rd, mem_wr, illegal, bus_err;
  logic [3:0]  NZCV, alu_op;
  logic [31:0] retired_cnt;
  logic [7:0]  strobes;

  int errors = 0;
  int checks = 0;

  localparam logic [7:0] S_F  = 8'hC0;
  localparam logic [7:0] S_D  = 8'h20;
  localparam logic [7:0] S_X  = 8'h10;
  localparam logic [7:0] S_MR = 8'h02;
  localparam logic [7:0] S_MW = 8'h01;
  localparam logic [7:0] S_WB = 8'h08;
  localparam logic [7:0] S_WL = 8'h0C;

  assign strobes = {write_ir, write_pc, latch_ab, latch_alu_out, rf_we, rf_wsel, mem_rd, mem_wr};

  multicycle_control_unit #(.CNT_W(32), .MEM_TO(15)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .IR            (IR),
    .W_IR_valid    (W_IR_valid),
    .alu_flags     (alu_flags),
    .mem_ready     (mem_ready),
    .write_ir      (write_ir),
    .write_pc      (write_pc),
    .NZCV          (NZCV),
    .alu_op        (alu_op),
    .alu_src_imm   (alu_src_imm),
    .latch_ab      (latch_ab),
    .latch_alu_out (latch_alu_out),
    .rf_we         (rf_we),
    .rf_wsel       (rf_wsel),
    .mem_rd        (mem_rd),
    .mem_wr        (mem_wr),
    .illegal       (illegal),
    .bus_err       (bus_err),
    .retired_cnt   (retired_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Each task starts and ends at negedge+1 in a FETCH cycle.
  task automatic test_reset;
    rst_n = 1'b0; IR = 32'h0; W_IR_valid = 1'b0; alu_flags = 4'h0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (strobes !== 8'h00) begin errors++; $display("FAIL reset_strobes got=%h exp=00", strobes); end
    checks++; if (NZCV !== 4'h0) begin errors++; $display("FAIL reset_nzcv got=%h exp=0", NZCV); end
    checks++; if (retired_cnt !== 32'd0) begin errors++; $display("FAIL reset_retired got=%0d exp=0", retired_cnt); end
    checks++; if ({illegal, bus_err} !== 2'b00) begin errors++; $display("FAIL reset_pulses got=%b exp=00", {illegal, bus_err}); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (strobes !== S_F) begin errors++; $display("FAIL first_fetch got=%h exp=%h", strobes, S_F); end
  endtask

  task automatic test_add;
    logic [7:0] exp [5];
    exp = '{S_F, S_D, S_X, S_WB, S_F};
    IR = 32'hE2821005; W_IR_valid = 1'b1; alu_flags = 4'hF;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      checks++; if (strobes !== exp[i]) begin errors++; $display("FAIL add_seq[%0d] got=%h exp=%h", i, strobes, exp[i]); end
      if (i == 2) begin
        checks++; if ({alu_op, alu_src_imm} !== 5'b0100_1) begin errors++; $display("FAIL add_alu got=%h/%b exp=4/1", alu_op, alu_src_imm); end
      end
    end
    checks++; if (retired_cnt !== 32'd1) begin errors++; $display("FAIL add_retired got=%0d exp=1", retired_cnt); end
    checks++; if (NZCV !== 4'h0) begin errors++; $display("FAIL add_nzcv got=%h exp=0", NZCV); end
  endtask

  task automatic test_cmp;
    logic [7:0] exp [4];
    exp = '{S_F, S_D, S_X, S_F};
    IR = 32'hE3510000; W_IR_valid = 1'b1; alu_flags = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      checks++; if (strobes !== exp[i]) begin errors++; $display("FAIL cmp_seq[%0d] got=%h exp=%h", i, strobes, exp[i]); end
      if (i == 2) begin
        checks++; if (alu_op !== 4'hA) begin errors++; $display("FAIL cmp_alu_op got=%h exp=a", alu_op); end
      end
    end
    checks++; if (NZCV !== 4'b0100) begin errors++; $display("FAIL cmp_nzcv got=%b exp=0100", NZCV); end
    checks++; if (retired_cnt !== 32'd2) begin errors++; $display("FAIL cmp_retired got=%0d exp=2", retired_cnt); end
  endtask

  task automatic test_skip;
    IR = 32'h12821005; W_IR_valid = 1'b0; alu_flags = 4'hF;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      checks++; if (strobes !== S_F) begin errors++; $display("FAIL skip_seq[%0d] got=%h exp=%h", i, strobes, S_F); end
    end
    checks++; if (retired_cnt !== 32'd2) begin errors++; $display("FAIL skip_retired got=%0d exp=2", retired_cnt); end
    checks++; if (NZCV !== 4'b0100) begin errors++; $display("FAIL skip_nzcv got=%b exp=0100", NZCV); end
  endtask

  task automatic test_load;
    logic [7:0] exp [8];
    exp = '{S_F, S_D, S_X, S_MR, S_MR, S_MR, S_WL, S_F};
    IR = 32'hE5910000; W_IR_valid = 1'b1; alu_flags = 4'hF; mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        @(negedge clk);
        mem_ready = (i == 5);
        W_IR_valid = 1'b0;
        #1;
      end
      checks++; if (strobes !== exp[i]) begin errors++; $display("FAIL load_seq[%0d] got=%h exp=%h", i, strobes, exp[i]); end
      if (i == 2) begin
        checks++; if ({alu_op, alu_src_imm} !== 5'b0100_1) begin errors++; $display("FAIL load_addr_alu got=%h/%b exp=4/1", alu_op, alu_src_imm); end
      end
    end
    checks++; if (retired_cnt !== 32'd3) begin errors++; $display("FAIL load_retired got=%0d exp=3", retired_cnt); end
    checks++; if (NZCV !== 4'b0100) begin errors++; $display("FAIL load_nzcv got=%b exp=0100", NZCV); end
  endtask

  // ready_at < 0: memory never answers; otherwise ready only in that cycle index
  task automatic test_store(input int ready_at, input logic [31:0] exp_ret);
    logic [7:0] exp_s;
    logic       exp_be;
    IR = 32'hE5810000; W_IR_valid = 1'b1; alu_flags = 4'hF; mem_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) begin
        @(negedge clk);
        mem_ready = (i == ready_at);
        W_IR_valid = 1'b0;
        #1;
      end
      exp_s  = (i == 0 || i >= 18) ? S_F : (i == 1) ? S_D : (i == 2) ? S_X : S_MW;
      exp_be = (ready_at < 0) && (i == 18);
      checks++; if (strobes !== exp_s) begin errors++; $display("FAIL store_seq[%0d] rdy=%0d got=%h exp=%h", i, ready_at, strobes, exp_s); end
      checks++; if (bus_err !== exp_be) begin errors++; $display("FAIL store_bus_err[%0d] rdy=%0d got=%b exp=%b", i, ready_at, bus_err, exp_be); end
    end
    checks++; if (retired_cnt !== exp_ret) begin errors++; $display("FAIL store_retired rdy=%0d got=%0d exp=%0d", ready_at, retired_cnt, exp_ret); end
  endtask

  task automatic test_adds;
    logic [7:0] exp [5];
    exp = '{S_F, S_D, S_X, S_WB, S_F};
    IR = 32'hE2911005; W_IR_valid = 1'b1; alu_flags = 4'b1001;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(negedge clk); W_IR_valid = 1'b0; #1; end
      checks++; if (strobes !== exp[i]) begin errors++; $display("FAIL adds_seq[%0d] got=%h exp=%h", i, strobes, exp[i]); end
    end
    checks++; if (NZCV !== 4'b1001) begin errors++; $display("FAIL adds_nzcv got=%b exp=1001", NZCV); end
    checks++; if (retired_cnt !== 32'd5) begin errors++; $display("FAIL adds_retired got=%0d exp=5", retired_cnt); end
  endtask

  task automatic test_illegal;
    logic [7:0] exp_s [4];
    logic       exp_il [4];
    exp_s  = '{S_F, S_D, S_F, S_F};
    exp_il = '{1'b0, 1'b0, 1'b1, 1'b0};
    IR = 32'hEC000000; W_IR_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(negedge clk); W_IR_valid = 1'b0; #1; end
      checks++; if (strobes !== exp_s[i]) begin errors++; $display("FAIL illegal_seq[%0d] got=%h exp=%h", i, strobes, exp_s[i]); end
      checks++; if (illegal !== exp_il[i]) begin errors++; $display("FAIL illegal_pulse[%0d] got=%b exp=%b", i, illegal, exp_il[i]); end
    end
    checks++; if (retired_cnt !== 32'd5) begin errors++; $display("FAIL illegal_retired got=%0d exp=5", retired_cnt); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] exp [4];
    exp = '{S_F, S_D, S_X, S_MR};
    IR = 32'hE5910000; W_IR_valid = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(negedge clk); W_IR_valid = 1'b0; #1; end
      checks++; if (strobes !== exp[i]) begin errors++; $display("FAIL rstmid_seq[%0d] got=%h exp=%h", i, strobes, exp[i]); end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (strobes !== 8'h00) begin errors++; $display("FAIL rstmid_strobes got=%h exp=00", strobes); end
    checks++; if (NZCV !== 4'h0) begin errors++; $display("FAIL rstmid_nzcv got=%h exp=0", NZCV); end
    checks++; if (retired_cnt !== 32'd0) begin errors++; $display("FAIL rstmid_retired got=%0d exp=0", retired_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (strobes !== S_F) begin errors++; $display("FAIL rstmid_fetch got=%h exp=%h", strobes, S_F); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_cmp();
    test_skip();
    test_load();
    test_store(-1, 32'd3);
    test_store(17, 32'd4);
    test_adds();
    test_illegal();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle control FSM directly downstream of the instruction-fetch stage.
- Drives fetch's write_ir/write_pc strobes and consumes the latched IR plus its condition-pass flag (W_IR_valid).
- Decodes ARM-style data-processing and load/store instructions, sequences register file, ALU and data-memory strobes, and owns the architectural NZCV register that fetch uses for condition evaluation.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- MEM_TO, 15, max cycles to wait for mem_ready before aborting (range 1..255).

Ports:
- clk  in  1  system clock; all state on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- IR  in  32  instruction register from fetch, valid from DECODE onward.
- W_IR_valid  in  1  condition-pass flag from fetch, sampled at end of FETCH.
- alu_flags  in  4  N,Z,C,V result flags from ALU, valid during EXEC.
- mem_ready  in  1  data memory completion for the current mem_rd/mem_wr.
- write_ir  out  1  IR load strobe to fetch.
- write_pc  out  1  PC+4 strobe to fetch.
- NZCV  out  4  architectural flags [3]=N [2]=Z [1]=C [0]=V, fed to fetch.
- alu_op  out  4  equals IR[24:21] in EXEC; 4'b0100 (ADD) in ADDR.
- alu_src_imm  out  1  ALU operand B from immediate: IR[25] for DP; 1 in ADDR.
- latch_ab  out  1  capture register-file read ports into A/B.
- latch_alu_out  out  1  capture ALU result.
- rf_we  out  1  register-file write enable.
- rf_wsel  out  1  write-back source: 0 = ALU result, 1 = memory data.
- mem_rd  out  1  data memory read request.
- mem_wr  out  1  data memory write request.
- illegal  out  1  one-cycle pulse on an undefined instruction class.
- bus_err  out  1  one-cycle pulse on memory timeout.
- retired_cnt  out  CNT_W  count of completed instructions.

Behaviour:
- Decode fields:
  - class = IR[27:26]: 00 = DP, 01 = LS, 1x = undefined.
  - DP: S = IR[20]; compare ops are IR[24:21] in 8..11 (TST/TEQ/CMP/CMN).
  - LS: L = IR[20] (1 = load).
- States and transitions:
  - FETCH → DECODE if W_IR_valid = 1, else FETCH (instruction skipped; PC already advanced).
  - DECODE → EXEC (DP) or ADDR (LS). Class 1x → FETCH with illegal = 1 for that cycle.
  - EXEC → FETCH for compare ops, else → WB.
  - ADDR → MEM_RD if L = 1, else MEM_WR.
  - MEM_RD → WB_LD on mem_ready. MEM_WR → FETCH on mem_ready.
  - WB → FETCH. WB_LD → FETCH.
- Outputs are Moore, decoded from the state register only (except illegal/bus_err, which are registered pulses):
  - FETCH: write_ir = 1, write_pc = 1.
  - DECODE: latch_ab = 1.
  - EXEC / ADDR: latch_alu_out = 1.
  - MEM_RD: mem_rd = 1. MEM_WR: mem_wr = 1.
  - WB: rf_we = 1, rf_wsel = 0. WB_LD: rf_we = 1, rf_wsel = 1.
  - All others 0.
- Flags: NZCV <= alu_flags on the clock edge leaving EXEC when S = 1 or the op is a compare. Unchanged otherwise. Stable throughout FETCH so fetch's condition check is glitch-free.
- Memory timeout:
  - An 8-bit wait counter is cleared on entry to MEM_RD/MEM_WR and increments each cycle mem_ready = 0.
  - When it reaches MEM_TO with mem_ready still 0: → FETCH, bus_err pulses one cycle, no rf_we, not retired.
  - mem_ready = 1 in the same cycle that the limit is hit counts as success.
- Latency: DP = 4 cycles (3 for compare); load = 5 + wait cycles; store = 4 + wait cycles; skipped = 1 cycle.
- retired_cnt: +1 on each transition WB→FETCH, WB_LD→FETCH, compare EXEC→FETCH, and successful MEM_WR→FETCH. Wraps modulo 2^CNT_W. Not incremented on skip, illegal or bus_err.
- Reset values: state = FETCH, NZCV = 0, retired_cnt = 0, wait counter = 0, illegal = 0, bus_err = 0; all strobes 0 while rst_n = 0.
- Reset asserted mid-operation aborts immediately: mem_rd/mem_wr/rf_we drop asynchronously, no partial retire.
- First FETCH occurs in the first cycle after rst_n deasserts.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - state encoding enum: FETCH, DECODE, EXEC, ADDR, MEM_RD, MEM_WR, WB, WB_LD;
  - class constants: DP = 2'b00, LS = 2'b01;
  - ALU opcode constants (ADD = 4'h4; TST..CMN = 4'h8..4'hB);
  - NZCV bit indices N = 3, Z = 2, C = 1, V = 0.
- One natural sub-module: mcu_mem_timer (wait counter plus timeout compare), instantiated for the MEM_RD/MEM_WR states.

Test Plan:
- Reset release, then IR = 32'hE2821005 (ADD R1,R2,#5, AL) → FETCH, DECODE, EXEC, WB across 4 cycles. rf_we = 1 and rf_wsel = 0 in WB only. alu_src_imm = 1 and alu_op = 4'h4 in EXEC. retired_cnt = 1. NZCV stays 0.
- IR = 32'hE3510000 (CMP R1,#0) with alu_flags = 4'b0100 → 3-cycle sequence, NZCV = 4'b0100 after EXEC, no rf_we, retired_cnt increments.
- NZCV = 4'b0100 and W_IR_valid = 0 for IR = 32'h12821005 (NE) → FETCH→FETCH in 1 cycle, write_pc pulses, no latch_ab/rf_we, retired_cnt unchanged.
- IR = 32'hE5910000 (LDR R0,[R1]) with mem_ready asserted after 2 wait cycles → ADDR, MEM_RD held 3 cycles, then WB_LD with rf_wsel = 1. Total 7 cycles.
- IR = 32'hE5810000 (STR) with mem_ready held 0 → mem_wr held exactly MEM_TO cycles, then bus_err = 1 for one cycle, return to FETCH, retired_cnt unchanged.
- IR = 32'hEC000000 (class 11) → illegal pulse in DECODE, then FETCH. Separately, rst_n driven low mid-MEM_RD → mem_rd = 0 immediately, state = FETCH, NZCV = 0, retired_cnt = 0.
